cpu_id: RTL and testbench



---
 rtl/cpu_id.sv | 160 ++++++++++++++++
 tb/tb_cpu_id.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_id.sv
// Instruction decoder for the one-cycle CPU: splits IN into opcode/operand and
// registers the control strobes. Define CPU_ID_ILLEGAL_TRAP_EN to trap illegal opcodes as RST.
module cpu_id #(
   parameter int WIDTH          = 13,
   parameter int IWIDTH         = 5,
   parameter int REG_F_SEL_SIZE = 4,
   parameter int IN_B_SEL_SIZE  = 2
) (
   input  logic                      CLK,
   input  logic                      RST_N,
   input  logic [WIDTH-1:0]          IN,
   output logic                      PC_RST,
   output logic                      PC_LD,
   output logic [IWIDTH-2:0]         ALU_OUT,
   output logic [WIDTH-IWIDTH-1:0]   IMM,
   output logic [IN_B_SEL_SIZE-1:0]  IN_B_SEL,
   output logic [REG_F_SEL_SIZE-1:0] REG_F_SEL,
   output logic                      EN_REG_F,
   output logic [WIDTH-IWIDTH-1:0]   D_MEM_ADDR,
   output logic                      D_MEM_ADDR_MODE,
   output logic                      EN_D_MEM,
   output logic                      EN_ACC,
   output logic                      JMP_MODE,
   output logic [WIDTH-IWIDTH-1:0]   BASE_REG_OFFSET,
   output logic                      BASE_REG_LD,
   output logic [WIDTH-IWIDTH-1:0]   BASE_REG_DATA
);

   localparam int D = WIDTH - IWIDTH;

   localparam logic [IWIDTH-1:0] OP_NOP  = IWIDTH'(5'b00000);
   localparam logic [IWIDTH-1:0] OP_RST  = IWIDTH'(5'b00001);
   localparam logic [IWIDTH-1:0] OP_LD   = IWIDTH'(5'b00010);
   localparam logic [IWIDTH-1:0] OP_ST   = IWIDTH'(5'b00011);
   localparam logic [IWIDTH-1:0] OP_LDR  = IWIDTH'(5'b00100);
   localparam logic [IWIDTH-1:0] OP_STR  = IWIDTH'(5'b00101);
   localparam logic [IWIDTH-1:0] OP_BAR  = IWIDTH'(5'b00110);
   localparam logic [IWIDTH-1:0] OP_JMP  = IWIDTH'(5'b00111);
   localparam logic [IWIDTH-1:0] OP_JMPO = IWIDTH'(5'b01000);
   localparam logic [IWIDTH-1:0] OP_LDI  = IWIDTH'(5'b01001);
   localparam logic [IWIDTH-1:0] OP_LDAR = IWIDTH'(5'b01010);
   localparam logic [IWIDTH-1:0] OP_XORR = IWIDTH'(5'b10010);
   localparam logic [IWIDTH-1:0] OP_ORR  = IWIDTH'(5'b10011);
   localparam logic [IWIDTH-1:0] OP_ANDR = IWIDTH'(5'b10100);
   localparam logic [IWIDTH-1:0] OP_ADDR = IWIDTH'(5'b10101);
   localparam logic [IWIDTH-1:0] OP_SUBR = IWIDTH'(5'b10110);

   localparam logic [IWIDTH-2:0] ALU_PASS_B = (IWIDTH-1)'(1);

   localparam logic [IN_B_SEL_SIZE-1:0] BSEL_IMM   = IN_B_SEL_SIZE'(0);
   localparam logic [IN_B_SEL_SIZE-1:0] BSEL_REG_F = IN_B_SEL_SIZE'(1);
   localparam logic [IN_B_SEL_SIZE-1:0] BSEL_DMEM  = IN_B_SEL_SIZE'(2);

   logic [IWIDTH-1:0] opcode;
   logic [D-1:0]      operand;

   logic                     pc_rst_nxt, pc_ld_nxt, en_reg_f_nxt, d_mem_addr_mode_nxt;
   logic                     en_d_mem_nxt, en_acc_nxt, jmp_mode_nxt, base_reg_ld_nxt;
   logic [IWIDTH-2:0]        alu_out_nxt;
   logic [IN_B_SEL_SIZE-1:0] in_b_sel_nxt;

   assign opcode  = IN[WIDTH-1:D];
   assign operand = IN[D-1:0];

   always_comb begin
      pc_rst_nxt          = 1'b0;
      pc_ld_nxt           = 1'b0;
      alu_out_nxt         = '0;
      in_b_sel_nxt        = BSEL_IMM;
      en_reg_f_nxt        = 1'b0;
      d_mem_addr_mode_nxt = 1'b0;
      en_d_mem_nxt        = 1'b0;
      en_acc_nxt          = 1'b0;
      jmp_mode_nxt        = 1'b0;
      base_reg_ld_nxt     = 1'b0;
      unique case (opcode)
         OP_NOP  : ;
         OP_RST  : pc_rst_nxt = 1'b1;
         OP_LD   : begin
            in_b_sel_nxt = BSEL_DMEM;
            alu_out_nxt  = ALU_PASS_B;
            en_acc_nxt   = 1'b1;
         end
         OP_ST   : en_d_mem_nxt = 1'b1;
         OP_LDR  : begin
            in_b_sel_nxt = BSEL_REG_F;
            alu_out_nxt  = ALU_PASS_B;
            en_acc_nxt   = 1'b1;
         end
         OP_STR  : en_reg_f_nxt = 1'b1;
         OP_BAR  : base_reg_ld_nxt = 1'b1;
         OP_JMP  : pc_ld_nxt = 1'b1;
         OP_JMPO : begin
            pc_ld_nxt    = 1'b1;
            jmp_mode_nxt = 1'b1;
         end
         OP_LDI  : begin
            in_b_sel_nxt = BSEL_IMM;
            alu_out_nxt  = ALU_PASS_B;
            en_acc_nxt   = 1'b1;
         end
         OP_LDAR : begin
            in_b_sel_nxt        = BSEL_DMEM;
            d_mem_addr_mode_nxt = 1'b1;
            alu_out_nxt         = ALU_PASS_B;
            en_acc_nxt          = 1'b1;
         end
         // Register ALU ops reuse the low opcode bits as the ALU code.
         OP_XORR, OP_ORR, OP_ANDR, OP_ADDR, OP_SUBR : begin
            in_b_sel_nxt = BSEL_REG_F;
            alu_out_nxt  = opcode[IWIDTH-2:0];
            en_acc_nxt   = 1'b1;
         end
         default : begin
`ifdef CPU_ID_ILLEGAL_TRAP_EN
            pc_rst_nxt = 1'b1;
`else
            pc_rst_nxt = 1'b0;
`endif
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         PC_RST          <= 1'b0;
         PC_LD           <= 1'b0;
         ALU_OUT         <= '0;
         IMM             <= '0;
         IN_B_SEL        <= '0;
         REG_F_SEL       <= '0;
         EN_REG_F        <= 1'b0;
         D_MEM_ADDR      <= '0;
         D_MEM_ADDR_MODE <= 1'b0;
         EN_D_MEM        <= 1'b0;
         EN_ACC          <= 1'b0;
         JMP_MODE        <= 1'b0;
         BASE_REG_OFFSET <= '0;
         BASE_REG_LD     <= 1'b0;
         BASE_REG_DATA   <= '0;
      end else begin
         PC_RST          <= pc_rst_nxt;
         PC_LD           <= pc_ld_nxt;
         ALU_OUT         <= alu_out_nxt;
         IMM             <= operand;
         IN_B_SEL        <= in_b_sel_nxt;
         REG_F_SEL       <= operand[REG_F_SEL_SIZE-1:0];
         EN_REG_F        <= en_reg_f_nxt;
         D_MEM_ADDR      <= operand;
         D_MEM_ADDR_MODE <= d_mem_addr_mode_nxt;
         EN_D_MEM        <= en_d_mem_nxt;
         EN_ACC          <= en_acc_nxt;
         JMP_MODE        <= jmp_mode_nxt;
         BASE_REG_OFFSET <= operand;
         BASE_REG_LD     <= base_reg_ld_nxt;
         BASE_REG_DATA   <= operand;
      end
   end

endmodule

// File: tb/tb_cpu_id.sv
// Scoreboard bench for cpu_id: stimulus pushes expected decodes, a monitor pops
// and compares one cycle later. Honours CPU_ID_ILLEGAL_TRAP_EN for illegal opcodes.
module tb_cpu_id;

   typedef struct packed {
      logic       pc_rst;
      logic       pc_ld;
      logic [3:0] alu;
      logic [7:0] imm;
      logic [1:0] bsel;
      logic [3:0] rsel;
      logic       en_reg_f;
      logic [7:0] dma;
      logic       dmode;
      logic       en_d_mem;
      logic       en_acc;
      logic       jmp_mode;
      logic [7:0] off;
      logic       base_ld;
      logic [7:0] base_data;
   } dec_t;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic [12:0] IN = '0;

   logic       PC_RST, PC_LD, EN_REG_F, D_MEM_ADDR_MODE, EN_D_MEM, EN_ACC, JMP_MODE, BASE_REG_LD;
   logic [3:0] ALU_OUT, REG_F_SEL;
   logic [7:0] IMM, D_MEM_ADDR, BASE_REG_OFFSET, BASE_REG_DATA;
   logic [1:0] IN_B_SEL;

   cpu_id dut (
      .CLK(CLK), .RST_N(RST_N), .IN(IN),
      .PC_RST(PC_RST), .PC_LD(PC_LD), .ALU_OUT(ALU_OUT), .IMM(IMM),
      .IN_B_SEL(IN_B_SEL), .REG_F_SEL(REG_F_SEL), .EN_REG_F(EN_REG_F),
      .D_MEM_ADDR(D_MEM_ADDR), .D_MEM_ADDR_MODE(D_MEM_ADDR_MODE),
      .EN_D_MEM(EN_D_MEM), .EN_ACC(EN_ACC), .JMP_MODE(JMP_MODE),
      .BASE_REG_OFFSET(BASE_REG_OFFSET), .BASE_REG_LD(BASE_REG_LD),
      .BASE_REG_DATA(BASE_REG_DATA)
   );

   always #5 CLK = ~CLK;

   dec_t got;
   assign got = '{PC_RST, PC_LD, ALU_OUT, IMM, IN_B_SEL, REG_F_SEL, EN_REG_F,
                  D_MEM_ADDR, D_MEM_ADDR_MODE, EN_D_MEM, EN_ACC, JMP_MODE,
                  BASE_REG_OFFSET, BASE_REG_LD, BASE_REG_DATA};

   int checks = 0;
   int failures = 0;
   dec_t  exp_q[$];
   string name_q[$];

   // Reference: instruction semantics described by mnemonic, B source and destination.
   function automatic dec_t model(input logic [4:0] op, input logic [7:0] opd);
      dec_t e = '0;
      string mn;
      e.imm = opd; e.dma = opd; e.off = opd; e.base_data = opd; e.rsel = opd[3:0];
      case (op)
         5'd0:  mn = "NOP";   5'd1:  mn = "RST";   5'd2:  mn = "LD";
         5'd3:  mn = "ST";    5'd4:  mn = "LDR";   5'd5:  mn = "STR";
         5'd6:  mn = "BAR";   5'd7:  mn = "JMP";   5'd8:  mn = "JMPO";
         5'd9:  mn = "LDI";   5'd10: mn = "LDAR";  5'd18: mn = "XORR";
         5'd19: mn = "ORR";   5'd20: mn = "ANDR";  5'd21: mn = "ADDR";
         5'd22: mn = "SUBR";
`ifdef CPU_ID_ILLEGAL_TRAP_EN
         default: mn = "RST";
`else
         default: mn = "NOP";
`endif
      endcase
      if (mn == "RST")  e.pc_rst = 1;
      if (mn == "JMP")  e.pc_ld = 1;
      if (mn == "JMPO") begin e.pc_ld = 1; e.jmp_mode = 1; end
      if (mn == "ST")   e.en_d_mem = 1;
      if (mn == "STR")  e.en_reg_f = 1;
      if (mn == "BAR")  e.base_ld = 1;
      // Accumulator loads: B comes from memory, register file or the immediate.
      if (mn == "LD" || mn == "LDAR") begin e.bsel = 2; e.alu = 1; e.en_acc = 1; end
      if (mn == "LDAR") e.dmode = 1;
      if (mn == "LDR")  begin e.bsel = 1; e.alu = 1; e.en_acc = 1; end
      if (mn == "LDI")  begin e.bsel = 0; e.alu = 1; e.en_acc = 1; end
      if (mn == "XORR" || mn == "ORR" || mn == "ANDR" || mn == "ADDR" || mn == "SUBR") begin
         e.bsel = 1; e.en_acc = 1;
         e.alu = (mn == "XORR") ? 4'd2 : (mn == "ORR") ? 4'd3 : (mn == "ANDR") ? 4'd4 :
                 (mn == "ADDR") ? 4'd5 : 4'd6;
      end
      return e;
   endfunction

   task automatic drive(input logic [4:0] op, input logic [7:0] opd, input string nm);
      IN = {op, opd};
      exp_q.push_back(model(op, opd));
      name_q.push_back(nm);
   endtask

   task automatic issue(input logic [4:0] op, input logic [7:0] opd, input string nm);
      @(negedge CLK);
      drive(op, opd, nm);
   endtask

   // Monitor
   initial begin
      dec_t  e;
      string n;
      forever begin
         @(posedge CLK);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (got !== e) begin
               failures++;
               $display("FAIL %s got=%h exp=%h", n, got, e);
            end
            checks++;
            if ((PC_RST && PC_LD) || (int'(EN_ACC) + int'(EN_REG_F) + int'(EN_D_MEM) > 1)) begin
               failures++;
               $display("FAIL %s_exclusive got pc=%b%b en=%b%b%b exp at most one set",
                        n, PC_RST, PC_LD, EN_ACC, EN_REG_F, EN_D_MEM);
            end
         end
      end
   end

   initial begin
      logic [4:0] op;
      logic [7:0] opd;
      int cyc;

      RST_N = 1'b0;
      IN = {5'd9, 8'h0F};
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      checks++;
      if (got !== '0) begin failures++; $display("FAIL reset_zero got=%h exp=0", got); end

      @(negedge CLK);
      RST_N = 1'b1;
      drive(5'd9, 8'h0F, "ldi_after_reset");

      issue(5'd2, 8'h09, "ld");
      issue(5'd3, 8'h06, "st");
      issue(5'd4, 8'h02, "ldr");
      issue(5'd5, 8'h07, "str");
      issue(5'd21, 8'h05, "addr");
      issue(5'd6, 8'hA1, "bar");
      issue(5'd7, 8'h2B, "jmp");
      issue(5'd8, 8'h0C, "jmpo");
      issue(5'd10, 8'h02, "ldar");
      issue(5'd18, 8'h3C, "xorr");
      issue(5'd19, 8'h0A, "orr");
      issue(5'd20, 8'hF9, "andr");
      issue(5'd22, 8'h0E, "subr");
      issue(5'd1, 8'h00, "rst");
      issue(5'd31, 8'h00, "illegal_1f");
      issue(5'd0, 8'hFF, "nop");
      issue(5'd2, 8'h77, "ld_before_reset");

      // Mid-stream reset: outputs clear immediately and the in-flight word is dropped.
      @(negedge CLK);
      RST_N = 1'b0;
      IN = {5'd9, 8'h55};
      #1;
      checks++;
      if (got !== '0) begin failures++; $display("FAIL async_reset got=%h exp=0", got); end
      @(posedge CLK);
      #1;
      checks++;
      if (got !== '0) begin failures++; $display("FAIL reset_hold got=%h exp=0", got); end
      @(negedge CLK);
      RST_N = 1'b1;
      drive(5'd10, 8'h33, "ldar_after_reset");

      for (int i = 0; i < 300; i++) begin
         op  = 5'($urandom_range(0, 31));
         opd = 8'($urandom);
         if (!(op <= 5'd10 || (op >= 5'd18 && op <= 5'd22))) opd = 8'h00;
         issue(op, opd, "random");
      end

      cyc = 0;
      while (exp_q.size() > 0 && cyc < 10) begin
         @(negedge CLK);
         cyc++;
      end
      if (exp_q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout got=%0d pending exp=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
